// File: rtl/dcache_pkg.sv
// Shared types and helpers for the direct-mapped write-back data cache.
// Holds the store width encodings, the controller state enum and the byte-lane helper.
package dcache_pkg;

   localparam logic [1:0] W_BYTE = 2'b00;
   localparam logic [1:0] W_HALF = 2'b01;
   localparam logic [1:0] W_WORD = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WB     = 2'd1,
      S_REFILL = 2'd2,
      S_DONE   = 2'd3
   } dcache_state_e;

   typedef struct packed {
      logic [3:0]  be;
      logic [31:0] data;
   } store_lanes_t;

   // Misaligned halves/words align down; width 2'b11 behaves as a full word.
   function automatic store_lanes_t store_lanes(input logic [1:0]  width,
                                                input logic [1:0]  off,
                                                input logic [31:0] wr_data);
      store_lanes_t r;
      case (width)
         W_BYTE: begin
            r.be   = 4'b0001 << off;
            r.data = {4{wr_data[7:0]}};
         end
         W_HALF: begin
            r.be   = off[1] ? 4'b1100 : 4'b0011;
            r.data = {2{wr_data[15:0]}};
         end
         default: begin
            r.be   = 4'b1111;
            r.data = wr_data;
         end
      endcase
      return r;
   endfunction

endpackage

// File: rtl/dcache_store_merge.sv
// Combinational byte-enable merge of store data into an existing cache word.
module dcache_store_merge
   import dcache_pkg::*;
(
   input  logic [31:0] old_word_i,
   input  logic [1:0]  off_i,
   input  logic [1:0]  width_i,
   input  logic [31:0] wr_data_i,
   output logic [31:0] new_word_o
);

   store_lanes_t lanes;

   always_comb begin
      lanes      = store_lanes(width_i, off_i, wr_data_i);
      new_word_o = old_word_i;
      for (int b = 0; b < 4; b++) begin
         if (lanes.be[b]) begin
            new_word_o[8*b +: 8] = lanes.data[8*b +: 8];
         end
      end
   end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache for the MEM stage.
// Misses evict (if dirty) and refill a whole line over a word-serial bus, stalling the pipe.
module dcache_ctrl
   import dcache_pkg::*;
#(
   parameter int SETS       = 64,
   parameter int LINE_WORDS = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_req_Dcache_i,
   input  logic        mem_rw_i,
   input  logic [31:0] mem_addr_i,
   input  logic [1:0]  mem_wrwidth_i,
   input  logic [31:0] mem_wr_data_i,
   output logic [31:0] dcache_rd_data_o,
   output logic        dcache_stall_o,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [31:0] bus_wdata_o,
   input  logic        bus_ack_i,
   input  logic [31:0] bus_rdata_i
);

   localparam int WORD_W  = $clog2(LINE_WORDS);
   localparam int IDX_W   = $clog2(SETS);
   localparam int TAG_W   = 32 - 2 - WORD_W - IDX_W;
   localparam int ENTRIES = SETS * LINE_WORDS;

   dcache_state_e     state_q, state_d;
   logic [WORD_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0]  miss_idx_q, miss_idx_d;
   logic [TAG_W-1:0]  miss_tag_q, miss_tag_d;
   logic [SETS-1:0]   valid_q, valid_d;
   logic [SETS-1:0]   dirty_q, dirty_d;
   logic [TAG_W-1:0]  tag_q  [SETS];
   logic [TAG_W-1:0]  tag_d  [SETS];
   logic [31:0]       data_q [ENTRIES];
   logic [31:0]       data_d [ENTRIES];

   logic [WORD_W-1:0] req_word;
   logic [IDX_W-1:0]  req_idx;
   logic [TAG_W-1:0]  req_tag;
   logic              hit;
   logic [31:0]       hit_word;
   logic [31:0]       merged_word;
   logic              last_word;

   assign req_word  = mem_addr_i[2 +: WORD_W];
   assign req_idx   = mem_addr_i[2+WORD_W +: IDX_W];
   assign req_tag   = mem_addr_i[31 -: TAG_W];
   assign hit       = mem_req_Dcache_i & valid_q[req_idx] & (tag_q[req_idx] == req_tag);
   assign hit_word  = data_q[{req_idx, req_word}];
   assign last_word = &cnt_q;

   dcache_store_merge u_store_merge (
      .old_word_i (hit_word),
      .off_i      (mem_addr_i[1:0]),
      .width_i    (mem_wrwidth_i),
      .wr_data_i  (mem_wr_data_i),
      .new_word_o (merged_word)
   );

   always_comb begin
      state_d          = state_q;
      cnt_d            = cnt_q;
      miss_idx_d       = miss_idx_q;
      miss_tag_d       = miss_tag_q;
      valid_d          = valid_q;
      dirty_d          = dirty_q;
      tag_d            = tag_q;
      data_d           = data_q;
      dcache_stall_o   = 1'b0;
      dcache_rd_data_o = '0;
      bus_req_o        = 1'b0;
      bus_we_o         = 1'b0;
      bus_addr_o       = '0;
      bus_wdata_o      = '0;

      case (state_q)
         S_IDLE: begin
            if (mem_req_Dcache_i) begin
               if (hit) begin
                  if (mem_rw_i) begin
                     data_d[{req_idx, req_word}] = merged_word;
                     dirty_d[req_idx]            = 1'b1;
                  end else begin
                     dcache_rd_data_o = hit_word;
                  end
               end else begin
                  dcache_stall_o   = 1'b1;
                  miss_idx_d       = req_idx;
                  miss_tag_d       = req_tag;
                  cnt_d            = '0;
                  valid_d[req_idx] = 1'b0;
                  state_d          = (valid_q[req_idx] & dirty_q[req_idx]) ? S_WB : S_REFILL;
               end
            end
         end
         S_WB: begin
            dcache_stall_o = 1'b1;
            bus_req_o      = 1'b1;
            bus_we_o       = 1'b1;
            bus_addr_o     = {tag_q[miss_idx_q], miss_idx_q, cnt_q, 2'b00};
            bus_wdata_o    = data_q[{miss_idx_q, cnt_q}];
            if (bus_ack_i) begin
               cnt_d = cnt_q + WORD_W'(1);
               if (last_word) begin
                  dirty_d[miss_idx_q] = 1'b0;
                  state_d             = S_REFILL;
               end
            end
         end
         S_REFILL: begin
            dcache_stall_o = 1'b1;
            bus_req_o      = 1'b1;
            bus_addr_o     = {miss_tag_q, miss_idx_q, cnt_q, 2'b00};
            if (bus_ack_i) begin
               data_d[{miss_idx_q, cnt_q}] = bus_rdata_i;
               cnt_d                       = cnt_q + WORD_W'(1);
               if (last_word) begin
                  tag_d[miss_idx_q]   = miss_tag_q;
                  valid_d[miss_idx_q] = 1'b1;
                  state_d             = S_DONE;
               end
            end
         end
         S_DONE: begin
            dcache_stall_o = 1'b1;
            state_d        = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs read as idle for the whole reset cycle, whatever state is being aborted.
      if (rst) begin
         dcache_stall_o   = 1'b0;
         dcache_rd_data_o = '0;
         bus_req_o        = 1'b0;
         bus_we_o         = 1'b0;
         bus_addr_o       = '0;
         bus_wdata_o      = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         miss_idx_q <= '0;
         miss_tag_q <= '0;
         valid_q    <= '0;
         dirty_q    <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         miss_idx_q <= miss_idx_d;
         miss_tag_q <= miss_tag_d;
         valid_q    <= valid_d;
         dirty_q    <= dirty_d;
      end
   end

   // Tag and data contents need no reset; the cleared valid bits hide them.
   always_ff @(posedge clk) begin
      tag_q  <= tag_d;
      data_q <= data_d;
   end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed scoreboard bench for dcache_ctrl with a word-serial memory model.
// Expected bus transfers and load data are queued when stimulus is issued and popped on completion.
module tb_dcache_ctrl;
   import dcache_pkg::*;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
   } bus_txn_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_req_Dcache_i;
   logic        mem_rw_i;
   logic [31:0] mem_addr_i;
   logic [1:0]  mem_wrwidth_i;
   logic [31:0] mem_wr_data_i;
   logic [31:0] dcache_rd_data_o;
   logic        dcache_stall_o;
   logic        bus_req_o;
   logic        bus_we_o;
   logic [31:0] bus_addr_o;
   logic [31:0] bus_wdata_o;
   logic        bus_ack_i;
   logic [31:0] bus_rdata_i;

   int          checks = 0;
   int          errors = 0;
   int          ack_wait;
   logic [31:0] mem [0:4095];
   bus_txn_t    bus_exp_q [$];
   logic [31:0] rd_exp_q [$];

   always #5 clk = ~clk;

   dcache_ctrl #(.SETS(64), .LINE_WORDS(4)) dut (
      .clk              (clk),
      .rst              (rst),
      .mem_req_Dcache_i (mem_req_Dcache_i),
      .mem_rw_i         (mem_rw_i),
      .mem_addr_i       (mem_addr_i),
      .mem_wrwidth_i    (mem_wrwidth_i),
      .mem_wr_data_i    (mem_wr_data_i),
      .dcache_rd_data_o (dcache_rd_data_o),
      .dcache_stall_o   (dcache_stall_o),
      .bus_req_o        (bus_req_o),
      .bus_we_o         (bus_we_o),
      .bus_addr_o       (bus_addr_o),
      .bus_wdata_o      (bus_wdata_o),
      .bus_ack_i        (bus_ack_i),
      .bus_rdata_i      (bus_rdata_i)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic req, input logic rw, input logic [31:0] addr,
                                input logic [1:0] width, input logic [31:0] wdata);
      mem_req_Dcache_i = req;
      mem_rw_i         = rw;
      mem_addr_i       = addr;
      mem_wrwidth_i    = width;
      mem_wr_data_i    = wdata;
   endtask

   task automatic expectBus(input logic we, input logic [31:0] addr, input logic [31:0] data);
      bus_txn_t t;
      t.we   = we;
      t.addr = addr;
      t.data = data;
      bus_exp_q.push_back(t);
   endtask

   task automatic expectRefill(input logic [31:0] base);
      for (int w = 0; w < 4; w++) expectBus(1'b0, base + 32'(4*w), 32'h0);
   endtask

   // Issues one request at posedge+1, holds it through any stall, then drops it.
   task automatic runAccess(input string tag, input logic rw, input logic [31:0] addr,
                            input logic [1:0] width, input logic [31:0] wdata,
                            input int exp_stalls, input logic [31:0] exp_rd);
      int          stalls;
      logic        done;
      logic [31:0] exp;
      stalls = 0;
      done   = 1'b0;
      if (!rw) rd_exp_q.push_back(exp_rd);
      applyStimulus(1'b1, rw, addr, width, wdata);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!dcache_stall_o) begin
            done = 1'b1;
            break;
         end
         stalls++;
      end
      checkOutput({tag, "_completed"}, 32'(done), 32'd1);
      checkOutput({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_stalls));
      if (!rw) begin
         exp = rd_exp_q.pop_front();
         checkOutput({tag, "_rd_data"}, dcache_rd_data_o, exp);
      end
      @(posedge clk);
      #1;
      applyStimulus(1'b0, 1'b0, 32'h0, W_WORD, 32'h0);
      checkOutput({tag, "_bus_pending"}, 32'(bus_exp_q.size()), 32'd0);
   endtask

   // Memory model: acks each requested word after ack_wait idle cycles.
   initial begin
      int          wait_cnt;
      logic [31:0] first_addr;
      bus_txn_t    t;
      bus_ack_i   = 1'b0;
      bus_rdata_i = '0;
      wait_cnt    = 0;
      first_addr  = '0;
      forever begin
         @(negedge clk);
         bus_ack_i = 1'b0;
         if (bus_req_o) begin
            if (wait_cnt == 0) first_addr = bus_addr_o;
            if (wait_cnt < ack_wait) begin
               wait_cnt++;
            end else begin
               if (ack_wait > 0) checkOutput("bus_addr_stable", bus_addr_o, first_addr);
               wait_cnt    = 0;
               bus_ack_i   = 1'b1;
               bus_rdata_i = mem[bus_addr_o[13:2]];
               if (bus_we_o) mem[bus_addr_o[13:2]] = bus_wdata_o;
               if (bus_exp_q.size() == 0) begin
                  checkOutput("bus_unexpected_txn", 32'(bus_exp_q.size()), 32'd1);
               end else begin
                  t = bus_exp_q.pop_front();
                  checkOutput("bus_we", 32'(bus_we_o), 32'(t.we));
                  checkOutput("bus_addr", bus_addr_o, t.addr);
                  if (t.we) checkOutput("bus_wdata", bus_wdata_o, t.data);
               end
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   initial begin
      logic found;
      for (int i = 0; i < 4096; i++) mem[i] = 32'hA000_0000 | 32'(i);
      mem[12'h010] = 32'h11; mem[12'h011] = 32'h22; mem[12'h012] = 32'h33; mem[12'h013] = 32'h44;
      mem[12'h410] = 32'h55; mem[12'h411] = 32'h66; mem[12'h412] = 32'h77; mem[12'h413] = 32'h88;
      ack_wait = 0;
      rst      = 1'b1;
      applyStimulus(1'b0, 1'b0, 32'h0, W_WORD, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_stall", 32'(dcache_stall_o), 32'd0);
      checkOutput("reset_bus_req", 32'(bus_req_o), 32'd0);
      checkOutput("reset_bus_we", 32'(bus_we_o), 32'd0);
      checkOutput("reset_bus_addr", bus_addr_o, 32'h0);
      checkOutput("reset_bus_wdata", bus_wdata_o, 32'h0);
      checkOutput("reset_rd_data", dcache_rd_data_o, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      expectRefill(32'h0000_0040);
      runAccess("cold_load", 1'b0, 32'h0000_0040, W_WORD, 32'h0, 6, 32'h11);

      runAccess("store_byte", 1'b1, 32'h0000_0042, W_BYTE, 32'h0000_00AB, 0, 32'h0);
      runAccess("hit_load", 1'b0, 32'h0000_0040, W_WORD, 32'h0, 0, 32'h00AB_0011);

      expectBus(1'b1, 32'h40, 32'h00AB_0011);
      expectBus(1'b1, 32'h44, 32'h22);
      expectBus(1'b1, 32'h48, 32'h33);
      expectBus(1'b1, 32'h4C, 32'h44);
      expectRefill(32'h0000_1040);
      runAccess("conflict_load", 1'b0, 32'h0000_1040, W_WORD, 32'h0, 10, 32'h55);

      expectRefill(32'h0000_0040);
      runAccess("clean_evict", 1'b0, 32'h0000_0040, W_WORD, 32'h0, 6, 32'h00AB_0011);
      expectRefill(32'h0000_1040);
      runAccess("reload", 1'b0, 32'h0000_1040, W_WORD, 32'h0, 6, 32'h55);

      runAccess("store_half", 1'b1, 32'h0000_1046, W_HALF, 32'h1234_BEEF, 0, 32'h0);
      runAccess("half_load", 1'b0, 32'h0000_1044, W_WORD, 32'h0, 0, 32'hBEEF_0066);
      runAccess("store_word_misaligned", 1'b1, 32'h0000_104B, 2'b11, 32'hCAFE_F00D, 0, 32'h0);
      runAccess("word_load", 1'b0, 32'h0000_1048, W_WORD, 32'h0, 0, 32'hCAFE_F00D);

      ack_wait = 3;
      expectBus(1'b1, 32'h1040, 32'h55);
      expectBus(1'b1, 32'h1044, 32'hBEEF_0066);
      expectBus(1'b1, 32'h1048, 32'hCAFE_F00D);
      expectBus(1'b1, 32'h104C, 32'h88);
      expectRefill(32'h0000_2040);
      runAccess("slow_bus", 1'b0, 32'h0000_2040, W_WORD, 32'h0, 34, 32'hA000_0810);

      ack_wait = 0;
      expectBus(1'b0, 32'h3040, 32'h0);
      expectBus(1'b0, 32'h3044, 32'h0);
      found = 1'b0;
      applyStimulus(1'b1, 1'b0, 32'h0000_3040, W_WORD, 32'h0);
      for (int i = 0; i < 50; i++) begin
         @(posedge clk);
         #1;
         if (bus_req_o && bus_addr_o == 32'h0000_3048) begin
            found = 1'b1;
            break;
         end
      end
      checkOutput("rst_reached_word2", 32'(found), 32'd1);
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 32'h0, W_WORD, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("post_rst_stall", 32'(dcache_stall_o), 32'd0);
      checkOutput("post_rst_bus_req", 32'(bus_req_o), 32'd0);
      checkOutput("post_rst_bus_addr", bus_addr_o, 32'h0);
      checkOutput("post_rst_bus_pending", 32'(bus_exp_q.size()), 32'd0);
      @(posedge clk);
      #1;
      expectRefill(32'h0000_3040);
      runAccess("reissue_after_rst", 1'b0, 32'h0000_3040, W_WORD, 32'h0, 6, 32'hA000_0C10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
